// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state encoding and CRC constants for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } ccff_state_t;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: bit-serial CRC-16-CCITT (MSB-first, no reflection, no final XOR).
// One bit absorbed per cycle with en; init has priority and reloads the seed.
module ccff_crc16
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ bit_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= CCFF_CRC_INIT;
    end else if (init) begin
      r_crc <= CCFF_CRC_INIT;
    end else if (en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CCFF_CRC_POLY : 16'h0000);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: byte stream -> MSB-first ccff_head with divided prog_clk; fabric held until CHAIN_LEN bits shifted.
// Start-to-done 1+ceil(CHAIN_LEN/8)+2*CLK_DIV*CHAIN_LEN cycles; stalls in FETCH on !byte_valid. CRC readback under CCFF_CRC_EN.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       fabric_hold,
  output logic       busy,
  output logic       done
`ifdef CCFF_CRC_EN
  ,
  output logic [15:0] crc_head,
  output logic [15:0] crc_tail
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  ccff_state_t      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_sr;
  logic             r_prog_clk, r_busy, r_done, r_hold;
  logic             w_start_ok, w_take, w_lo_last, w_hi_last, w_div_last, w_byte_ready;

  assign w_div_last   = (r_div == DIV_LAST);
  assign w_byte_ready = (r_state == FETCH) && !abort;
  assign w_take       = w_byte_ready && byte_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_lo_last  = 1'b0;
    w_hi_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = FETCH;
          w_start_ok = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          w_next = IDLE;
        end else if (start) begin
          w_next     = FETCH;
          w_start_ok = 1'b1;
        end
      end
      FETCH: begin
        if (abort)       w_next = IDLE;
        else if (w_take) w_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_div_last) begin
          w_next    = SHIFT_HI;
          w_lo_last = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_div_last) begin
          w_hi_last = 1'b1;
          if (r_cnt == CNT_LAST)   w_next = DONE;
          else if (r_bit == 3'd7)  w_next = FETCH;
          else                     w_next = SHIFT_LO;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The register only shifts between bits of a byte, so its MSB is ccff_head and stays put in FETCH/DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_div <= '0;
      r_bit <= '0;
      r_sr  <= '0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= '0;
        r_bit <= '0;
        r_div <= '0;
      end
      if (w_take) begin
        r_sr  <= byte_data;
        r_bit <= '0;
        r_div <= '0;
      end
      if ((r_state == SHIFT_LO || r_state == SHIFT_HI) && !abort) begin
        r_div <= w_div_last ? '0 : r_div + 1'b1;
      end
      if (w_hi_last) begin
        r_cnt <= r_cnt + 1'b1;
        r_bit <= r_bit + 1'b1;
        if (w_next == SHIFT_LO) r_sr <= {r_sr[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prog_clk <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hold     <= 1'b1;
    end else begin
      r_prog_clk <= (w_next == SHIFT_HI);
      r_busy     <= (w_next inside {FETCH, SHIFT_LO, SHIFT_HI});
      r_done     <= (w_next == DONE);
      r_hold     <= (w_next != DONE);
    end
  end

  assign byte_ready  = w_byte_ready;
  assign prog_clk    = r_prog_clk;
  assign ccff_head   = r_sr[7];
  assign fabric_hold = r_hold;
  assign busy        = r_busy;
  assign done        = r_done;

`ifdef CCFF_CRC_EN
  ccff_crc16 u_crc_head (
    .clk    (clk),
    .reset  (reset),
    .init   (w_start_ok),
    .en     (w_hi_last),
    .bit_in (r_sr[7]),
    .crc    (crc_head)
  );

  ccff_crc16 u_crc_tail (
    .clk    (clk),
    .reset  (reset),
    .init   (w_start_ok),
    .en     (w_lo_last),
    .bit_in (ccff_tail),
    .crc    (crc_tail)
  );
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a 16-bit and a 12-bit chain instance, each driving a shift-register model of the fabric.
module tb_ccff_loader;

  localparam int DIV = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start_v [2];
  logic       abort_v [2];
  logic       valid_v [2];
  logic [7:0] data_v  [2];
  logic       tail_v  [2];
  logic       ready_v [2];
  logic       pclk_v  [2];
  logic       head_v  [2];
  logic       hold_v  [2];
  logic       busy_v  [2];
  logic       done_v  [2];
`ifdef CCFF_CRC_EN
  logic [15:0] crch_v [2];
  logic [15:0] crct_v [2];
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic q0 [$];
  logic q1 [$];
  int   edges [2];
  logic prev_pclk [2] = '{1'b0, 1'b0};
  logic prev_head [2] = '{1'b0, 1'b0};
  logic mon_exp;
  logic [15:0] chain0 = 16'h0000;
  logic [15:0] chain1 = 16'h0000;

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(16), .CLK_DIV(DIV)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .byte_data(data_v[0]), .byte_valid(valid_v[0]), .byte_ready(ready_v[0]),
    .prog_clk(pclk_v[0]), .ccff_head(head_v[0]), .ccff_tail(tail_v[0]),
    .fabric_hold(hold_v[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef CCFF_CRC_EN
    , .crc_head(crch_v[0]), .crc_tail(crct_v[0])
`endif
  );

  ccff_loader #(.CHAIN_LEN(12), .CLK_DIV(DIV)) u_dut12 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .byte_data(data_v[1]), .byte_valid(valid_v[1]), .byte_ready(ready_v[1]),
    .prog_clk(pclk_v[1]), .ccff_head(head_v[1]), .ccff_tail(tail_v[1]),
    .fabric_hold(hold_v[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef CCFF_CRC_EN
    , .crc_head(crch_v[1]), .crc_tail(crct_v[1])
`endif
  );

  // Fabric models: each prog_clk rising edge shifts ccff_head into the chain.
  always @(posedge pclk_v[0]) chain0 <= {chain0[14:0], head_v[0]};
  always @(posedge pclk_v[1]) chain1 <= {chain1[14:0], head_v[1]};
  assign tail_v[0] = chain0[15];
  assign tail_v[1] = chain1[11];

  // Scoreboard consumer: every prog_clk rising edge must present the next expected head bit.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pclk_v[i] === 1'b1 && prev_pclk[i] === 1'b0) begin
        edges[i]++;
        n_checks++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          n_fail++;
          $display("FAIL extra_edge inst%0d: rising edge %0d with no expected bit", i, edges[i]);
        end else begin
          if (i == 0) mon_exp = q0.pop_front();
          else        mon_exp = q1.pop_front();
          if (head_v[i] !== mon_exp) begin
            n_fail++;
            $display("FAIL head_bit inst%0d edge %0d: got %b want %b", i, edges[i], head_v[i], mon_exp);
          end
        end
      end
      if (pclk_v[i] === 1'b1 && prev_pclk[i] === 1'b1) begin
        n_checks++;
        if (head_v[i] !== prev_head[i]) begin
          n_fail++;
          $display("FAIL head_stable inst%0d: changed to %b while prog_clk high", i, head_v[i]);
        end
      end
      prev_pclk[i] = pclk_v[i];
      prev_head[i] = head_v[i];
    end
  end

`ifdef CCFF_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] bits, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = n - 1; k >= 0; k--) begin
      fb = c[15] ^ bits[k];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  // Full load on instance i with a third byte always on offer; stall drops valid for that many FETCH cycles of byte 2.
  task automatic run_load(input int i, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int stall, input int exp_lat, input string name);
    logic [7:0]  bb [3];
    logic [15:0] exp_chain, mask, chain_now;
    int nbits, nbytes, idx, hs, lat, stall_left;
    logic pend, v;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    nbits  = (i == 0) ? 16 : 12;
    nbytes = (nbits + 7) / 8;
    mask   = (i == 0) ? 16'hFFFF : 16'h0FFF;
    exp_chain = 16'h0000;
    for (int k = 0; k < nbits; k++) begin
      v = bb[k / 8][7 - (k % 8)];
      exp_chain = {exp_chain[14:0], v};
      if (i == 0) q0.push_back(v);
      else        q1.push_back(v);
    end
    @(negedge clk);
    edges[i] = 0; idx = 0; hs = 0; lat = -1; stall_left = stall; pend = 1'b0;
    start_v[i] = 1'b1; valid_v[i] = 1'b1; data_v[i] = bb[0];
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start_v[i] = 1'b0;
      if (pend) begin idx++; hs++; end
      if (done_v[i] === 1'b1) begin lat = cyc; break; end
      v = (idx < 3);
      if (idx == 1 && ready_v[i] === 1'b1 && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
        n_checks++;
        if (pclk_v[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall_pclk: got %b want 0", name, pclk_v[i]);
        end
      end
      valid_v[i] = v;
      data_v[i]  = bb[(idx < 3) ? idx : 2];
      pend = (ready_v[i] === 1'b1) && v;
    end
    valid_v[i] = 1'b0;
    chain_now = (i == 0) ? chain0 : chain1;
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d (-1 = timeout)", name, lat, exp_lat); end
    n_checks++; if (hold_v[i] !== 1'b0) begin n_fail++; $display("FAIL %s fabric_hold: got %b want 0", name, hold_v[i]); end
    n_checks++; if (busy_v[i] !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", name, busy_v[i]); end
    n_checks++; if (ready_v[i] !== 1'b0) begin n_fail++; $display("FAIL %s byte_ready: got %b want 0", name, ready_v[i]); end
    n_checks++; if (edges[i] != nbits) begin n_fail++; $display("FAIL %s edges: got %0d want %0d", name, edges[i], nbits); end
    n_checks++; if (hs != nbytes) begin n_fail++; $display("FAIL %s handshakes: got %0d want %0d", name, hs, nbytes); end
    n_checks++;
    if ((chain_now & mask) !== (exp_chain & mask)) begin
      n_fail++;
      $display("FAIL %s chain: got %h want %h", name, chain_now & mask, exp_chain & mask);
    end
    n_checks++;
    if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
      n_fail++;
      $display("FAIL %s bits_left: got %0d want 0", name, (i == 0) ? q0.size() : q1.size());
    end
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (pclk_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset prog_clk: got %b want 0", pclk_v[0]); end
    n_checks++; if (head_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset ccff_head: got %b want 0", head_v[0]); end
    n_checks++; if (ready_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset byte_ready: got %b want 0", ready_v[0]); end
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy_v[0]); end
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done_v[0]); end
    n_checks++; if (hold_v[0] !== 1'b1) begin n_fail++; $display("FAIL reset fabric_hold: got %b want 1", hold_v[0]); end
    n_checks++; if (hold_v[1] !== 1'b1) begin n_fail++; $display("FAIL reset fabric_hold12: got %b want 1", hold_v[1]); end
`ifdef CCFF_CRC_EN
    n_checks++; if (crch_v[0] !== 16'hFFFF) begin n_fail++; $display("FAIL reset crc_head: got %h want ffff", crch_v[0]); end
    n_checks++; if (crct_v[0] !== 16'hFFFF) begin n_fail++; $display("FAIL reset crc_tail: got %h want ffff", crct_v[0]); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL restart busy: got %b want 1", busy_v[0]); end
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL restart done: got %b want 0", done_v[0]); end
    n_checks++; if (hold_v[0] !== 1'b1) begin n_fail++; $display("FAIL restart fabric_hold: got %b want 1", hold_v[0]); end
    start_v[0] = 1'b0;
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL restart_abort busy: got %b want 0", busy_v[0]); end
  endtask

  task automatic test_abort();
    logic [15:0] pat;
    pat = 16'hA53C;
    for (int k = 15; k >= 0; k--) q0.push_back(pat[k]);
    @(negedge clk);
    edges[0] = 0;
    start_v[0] = 1'b1; valid_v[0] = 1'b1; data_v[0] = 8'hA5;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (edges[0] >= 5) break;
    end
    n_checks++; if (edges[0] != 5) begin n_fail++; $display("FAIL abort reach_5_edges: got %0d want 5", edges[0]); end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    valid_v[0] = 1'b0;
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", busy_v[0]); end
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b want 0", done_v[0]); end
    n_checks++; if (hold_v[0] !== 1'b1) begin n_fail++; $display("FAIL abort fabric_hold: got %b want 1", hold_v[0]); end
    n_checks++; if (pclk_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort prog_clk: got %b want 0", pclk_v[0]); end
    n_checks++; if (ready_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort byte_ready: got %b want 0", ready_v[0]); end
    q0.delete();
    repeat (40) @(negedge clk);
    n_checks++; if (edges[0] != 5) begin n_fail++; $display("FAIL abort edges_after: got %0d want 5", edges[0]); end
    run_load(0, 8'hA5, 8'h3C, 8'h00, 0, 67, "reload");
  endtask

`ifdef CCFF_CRC_EN
  task automatic test_crc_readback();
    logic [15:0] h1;
    run_load(0, 8'hA5, 8'h3C, 8'h00, 0, 67, "crc_load1");
    h1 = crch_v[0];
    n_checks++; if (h1 !== crc_model(16'hA53C, 16)) begin n_fail++; $display("FAIL crc_head: got %h want %h", h1, crc_model(16'hA53C, 16)); end
    run_load(0, 8'hA5, 8'h3C, 8'h00, 0, 67, "crc_load2");
    n_checks++; if (crct_v[0] !== h1) begin n_fail++; $display("FAIL crc_readback: got %h want %h", crct_v[0], h1); end
  endtask
`endif

  task automatic test_async_reset();
    logic [15:0] pat;
    pat = 16'hA53C;
    for (int k = 15; k >= 0; k--) q0.push_back(pat[k]);
    @(negedge clk);
    start_v[0] = 1'b1; valid_v[0] = 1'b1; data_v[0] = 8'hA5;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (pclk_v[0] === 1'b1) break;
    end
    n_checks++; if (pclk_v[0] !== 1'b1) begin n_fail++; $display("FAIL areset reach_shift_hi: got %b want 1", pclk_v[0]); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pclk_v[0] !== 1'b0) begin n_fail++; $display("FAIL areset prog_clk: got %b want 0", pclk_v[0]); end
    n_checks++; if (hold_v[0] !== 1'b1) begin n_fail++; $display("FAIL areset fabric_hold: got %b want 1", hold_v[0]); end
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL areset busy: got %b want 0", busy_v[0]); end
    @(negedge clk);
    valid_v[0] = 1'b0;
    reset = 1'b0;
    q0.delete();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; valid_v[i] = 1'b0; data_v[i] = 8'h00; edges[i] = 0;
    end
    test_reset();
    run_load(0, 8'hA5, 8'h3C, 8'h00, 0, 67, "basic_load");
    run_load(1, 8'hFF, 8'h9F, 8'h55, 0, 51, "partial_byte");
    run_load(0, 8'hA5, 8'h3C, 8'h00, 10, 77, "stall");
    test_back_to_back();
    test_abort();
`ifdef CCFF_CRC_EN
    test_crc_readback();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the on-chip FPGA fabric. Accepts a bitstream as a byte stream over a valid/ready handshake, serializes it MSB-first onto the fabric's `ccff_head`, and generates `prog_clk` at a programmable division of `clk`. It holds the fabric in reset while loading and releases it only after exactly `CHAIN_LEN` bits have been shifted. It sits between the host-facing input pins and `fpga_top`, replacing direct pin drive of `prog_clk` and `ccff_head`.

## Interface
Parameters:
- `CHAIN_LEN`, 1024 — number of configuration flip-flops in the chain (≥1).
- `CLK_DIV`, 2 — `clk` cycles per `prog_clk` half-period (≥1).

Ports:
- `clk` in 1 — system clock; all logic on the rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `start` in 1 — begin a load. Sampled in IDLE or DONE; ignored while busy.
- `abort` in 1 — cancel a load in progress; returns to IDLE.
- `byte_data` in 8 — bitstream byte; bit 7 is shifted first.
- `byte_valid` in 1 — `byte_data` is valid.
- `byte_ready` out 1 — loader accepts a byte this cycle.
- `prog_clk` out 1 — configuration chain clock to the fabric.
- `ccff_head` out 1 — serial configuration data to the fabric.
- `ccff_tail` in 1 — serial output from the end of the chain.
- `fabric_hold` out 1 — active-high hold; drives the fabric reset.
- `busy` out 1 — load in progress.
- `done` out 1 — sticky; last load completed.
- `crc_head` out 16 — present only with `CCFF_CRC_EN`.
- `crc_tail` out 16 — present only with `CCFF_CRC_EN`.

## Operation
- **Reset values:**
  - `prog_clk`=0, `ccff_head`=0, `byte_ready`=0, `busy`=0, `done`=0.
  - `fabric_hold`=1, because the fabric is unconfigured.
  - `crc_*`=16'hFFFF.
  - State is IDLE.
- **States:** IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
- **IDLE or DONE, with `start`:**
  - Clear `done`, assert `busy` and `fabric_hold`.
  - Clear the bit counter, reinitialize the CRCs.
  - Go to FETCH.
- **FETCH:**
  - `byte_ready`=1 and `prog_clk`=0.
  - On `byte_valid & byte_ready`, latch the byte into the shift register and go to SHIFT_LO.
  - With no valid byte, the loader stalls indefinitely with `prog_clk` low. Stalling is legal.
- **SHIFT_LO** (`CLK_DIV` cycles):
  - `ccff_head` = shift-register MSB; `prog_clk`=0.
  - On the last cycle, sample `ccff_tail`.
  - Go to SHIFT_HI.
- **SHIFT_HI** (`CLK_DIV` cycles):
  - `prog_clk`=1 and `ccff_head` held stable.
  - On exit, increment the bit counter and shift the register left.
  - If the counter equals `CHAIN_LEN`, go to DONE.
  - Else, if 8 bits of this byte have been used, go to FETCH.
  - Else, go to SHIFT_LO.
- **DONE:**
  - `prog_clk`=0, `busy`=0, `done`=1, `fabric_hold`=0.
  - `ccff_head` keeps its last value.
- **Partial last byte:** when `CHAIN_LEN` mod 8 ≠ 0, the final byte contributes only its top `CHAIN_LEN` mod 8 bits. Its remaining bits are discarded and no extra byte is requested.
- **Abort:**
  - Takes effect in any non-IDLE state and takes priority over `start`.
  - Next cycle: IDLE, `prog_clk`=0, `busy`=0, `done`=0.
  - `fabric_hold` stays 1, because the configuration is invalid.
  - A byte presented in the same cycle as `abort` is not accepted.
- **Counter width:** `$clog2(CHAIN_LEN+1)`. It never wraps. Comparison is exact equality.

## Timing
- `prog_clk` period = 2·`CLK_DIV` `clk` cycles, 50% duty cycle.
- `ccff_head` changes only when `prog_clk` is low, at least `CLK_DIV` cycles before the rising edge.
- `ccff_tail` is sampled in the last `clk` cycle before each `prog_clk` rising edge.
- **Completion latency**, with `byte_valid` held high and B = ceil(`CHAIN_LEN`/8): `done` rises exactly 1 + B + 2·`CLK_DIV`·`CHAIN_LEN` cycles after the cycle in which `start` was sampled.
- `fabric_hold` falls in the same cycle that `done` rises.
- `start` and `abort` are level-sampled each cycle. Holding `start` high while in DONE restarts the load every time DONE is entered.

## Configuration
- **`CCFF_CRC_EN` defined:**
  - Instantiates two bit-serial CRC-16-CCITT engines (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR).
  - `crc_head` absorbs each `ccff_head` bit at SHIFT_HI exit.
  - `crc_tail` absorbs each sampled `ccff_tail` bit.
  - Both reinitialize on `start`, hold value in DONE and IDLE, and are reset to 16'hFFFF.
  - `crc_tail` gives readback of the previous fabric contents.
- **`CCFF_CRC_EN` undefined:** no CRC logic, and the `crc_head`/`crc_tail` ports do not exist.

## Structure
- **Package `ccff_pkg`:**
  - State enum `ccff_state_t`.
  - Constants `CCFF_CRC_POLY`=16'h1021 and `CCFF_CRC_INIT`=16'hFFFF.
- **Sub-module `ccff_crc16`:**
  - Ports: `clk`, `reset`, `init`, `en`, `bit_in`, `crc` (16 bits).
  - Instantiated twice, under the macro only.

## Test plan
- **Basic load** (`CHAIN_LEN`=16, `CLK_DIV`=2): bytes 0xA5, 0x3C with valid held high → head bit sequence 1010010100111100, 16 `prog_clk` rising edges, `done`=1 and `fabric_hold`=0 exactly 67 cycles after `start`.
- **Partial byte** (`CHAIN_LEN`=12): bytes 0xFF, 0x9F → head bits 111111111001, exactly 2 byte handshakes, 12 rising edges, no third `byte_ready` pulse.
- **Stall:** drop `byte_valid` for 10 cycles before the second byte → `prog_clk` stays low throughout, completion is delayed by exactly 10 cycles, bit sequence unchanged.
- **Abort:** assert `abort` after 5 `prog_clk` edges → next cycle IDLE, `busy`=0, `done`=0, `fabric_hold`=1, no further edges. A subsequent `start` reloads the chain fully.
- **CRC readback** (`CCFF_CRC_EN`): load 0xA5, 0x3C twice → `crc_tail` after the second load equals `crc_head` after the first load.
- **Async reset:** assert `reset` mid-SHIFT_HI → `prog_clk`=0 and `fabric_hold`=1 immediately, without waiting for a `clk` edge, and `busy`=0.
